// File: rtl/serial_adder_ctrl_if.sv
// Handshake/data bundle for the bit-serial adder.
//   master side (requester): drives start, a, b, cin; observes busy, done, sum, cout
//   slave side  (adder)    : observes start, a, b, cin; drives busy, done, sum, cout
interface serial_adder_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout
  );
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder built around one 1-bit full-adder cell.
// A start seen in IDLE captures a, b and cin; the operands are then fed to the
// cell one bit per clock, LSB first, with the carry kept in a flop. The result
// is assembled in a shift register and copied to sum/cout on the last bit.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of serial_adder_ctrl_if
//           start/a/b/cin in; busy (SHIFT or DONE), done (1-cycle pulse),
//           sum/cout (held between operations) out

// 1-bit full-adder cell.
module serial_adder_fa (
  input  logic a_i,
  input  logic b_i,
  input  logic cin_i,
  output logic sum_o,
  output logic cout_o
);
  assign sum_o  = a_i ^ b_i ^ cin_i;
  assign cout_o = (a_i & b_i) | (cin_i & (a_i ^ b_i));
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  serial_adder_ctrl_if.slave bus
);
  // One extra bit so the counter can represent WIDTH without wrapping at 32.
  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;

  logic             fa_sum;
  logic             fa_cout;

  serial_adder_fa u_fa (
    .a_i    (a_q[0]),
    .b_i    (b_q[0]),
    .cin_i  (carry_q),
    .sum_o  (fa_sum),
    .cout_o (fa_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.b;
          carry_d = bus.cin;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        // Shift then overwrite the MSB; this form also holds for WIDTH=1.
        res_d             = res_q >> 1;
        res_d[WIDTH-1]    = fa_sum;
        carry_d           = fa_cout;
        cnt_d             = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          sum_d   = res_d;
          cout_d  = fa_cout;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.busy = (state_q != IDLE);
  assign bus.done = (state_q == DONE);
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
module tb_serial_adder_ctrl;
  logic clk;
  logic rst_n;
  logic rnd_mode;
  int   fin_cnt;
  int   total_checks;
  int   passed_checks;

  // Directed stimulus (used by the WIDTH=8 instance only)
  logic       d_start;
  logic [7:0] d_a, d_b;
  logic       d_cin;

  // Views of the WIDTH=8 instance and its model
  logic [7:0] s8;
  logic       c8, b8, dn8;
  logic [8:0] em8;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total_checks++;
    if (got === exp) passed_checks++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  for (genvar gi = 0; gi < 3; gi++) begin : gw
    localparam int W = (gi == 0) ? 1 : ((gi == 1) ? 8 : 32);

    logic         r_start;
    logic [W-1:0] r_a, r_b;
    logic         r_cin;
    int           ops;
    int           cyc;
    int           last_done;
    int           ph;
    logic [W-1:0] es;
    logic         ec;
    logic [W:0]   res;

    serial_adder_ctrl_if #(.WIDTH(W)) u_if ();

    serial_adder_ctrl #(.WIDTH(W)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (u_if.slave)
    );

    assign u_if.start = rnd_mode ? r_start : ((W == 8) && d_start);
    assign u_if.a     = rnd_mode ? r_a : W'(d_a);
    assign u_if.b     = rnd_mode ? r_b : W'(d_b);
    assign u_if.cin   = rnd_mode ? r_cin : d_cin;

    if (W == 8) begin : g8
      assign s8  = u_if.sum;
      assign c8  = u_if.cout;
      assign b8  = u_if.busy;
      assign dn8 = u_if.done;
      assign em8 = {ec, es};
    end

    // Reference model: ph counts cycles since the accepted start
    // (0 = idle). Result is plain a+b+cin, published WIDTH edges after accept.
    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        ph = 0;
        es = '0;
        ec = 1'b0;
      end else if (ph == 0) begin
        if (u_if.start) begin
          ph  = 1;
          res = {1'b0, u_if.a} + {1'b0, u_if.b} + (W + 1)'(u_if.cin);
        end
      end else begin
        ph = ph + 1;
        if (ph == W + 1) {ec, es} = res;
        else if (ph == W + 2) ph = 0;
      end
    end

    // Compare DUT against model every cycle.
    initial begin
      cyc = 0;
      ops = 0;
      last_done = -1;
      forever begin
        @(negedge clk);
        cyc++;
        check($sformatf("w%0d_cycle%0d", W, cyc),
              64'({u_if.busy, u_if.done, u_if.cout, u_if.sum}),
              64'({ph != 0, ph == W + 1, ec, es}));
        if (!rnd_mode) last_done = -1;
        else if (u_if.done && r_start) begin
          ops++;
          if (last_done >= 0)
            check($sformatf("w%0d_done_spacing", W), 64'(cyc - last_done), 64'(W + 2));
          last_done = cyc;
        end
      end
    end

    // Random stimulus: start held high, operands change every cycle.
    initial begin
      r_start = 1'b0;
      r_a = '0;
      r_b = '0;
      r_cin = 1'b0;
      wait (rnd_mode);
      for (int n = 0; n < 1000 * (W + 2) + 200 && ops < 1000; n++) begin
        @(negedge clk);
        r_start = 1'b1;
        r_a = W'($urandom);
        r_b = W'($urandom);
        r_cin = 1'($urandom);
      end
      check($sformatf("w%0d_ops_done", W), 64'(ops >= 1000), 64'd1);
      r_start = 1'b0;
      fin_cnt++;
    end
  end

  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic c,
                      input int poke_k, input int rst_k,
                      output logic [8:0] result, output logic [8:0] held,
                      output int busy_cycles, output int dones);
    @(negedge clk);
    d_a = a; d_b = b; d_cin = c; d_start = 1'b1;
    @(negedge clk);
    d_start = 1'b0;
    busy_cycles = 0;
    dones = 0;
    result = '0;
    held = '0;
    for (int k = 0; k < 20; k++) begin
      if (k == poke_k) begin d_start = 1'b1; d_a = 8'hFF; end
      if (k == poke_k + 1) d_start = 1'b0;
      if (k == rst_k) begin
        rst_n = 1'b0;
        #1;
        check("mid_reset_outputs", 64'({b8, dn8, c8, s8}), 64'd0);
      end
      if (k == rst_k + 2) rst_n = 1'b1;
      if (k == 3) held = {c8, s8};
      if (b8) busy_cycles++;
      if (dn8) begin dones++; result = {c8, s8}; end
      @(negedge clk);
    end
  endtask

  initial begin
    logic [8:0] r, h;
    int bc, dc;
    total_checks = 0;
    passed_checks = 0;
    fin_cnt = 0;
    rnd_mode = 1'b0;
    d_start = 1'b0; d_a = '0; d_b = '0; d_cin = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_state", 64'({b8, dn8, c8, s8}), 64'd0);
    rst_n = 1'b1;

    run8(8'hFF, 8'h01, 1'b0, -5, -5, r, h, bc, dc);
    check("ff_01_result", 64'(r), 64'h100);
    check("ff_01_busy_cycles", 64'(bc), 64'd9);
    check("ff_01_dones", 64'(dc), 64'd1);
    check("ff_01_model_pin", 64'(em8), 64'h100);

    run8(8'h00, 8'h00, 1'b1, -5, -5, r, h, bc, dc);
    check("00_00_c1_result", 64'(r), 64'h001);

    run8(8'hA5, 8'h5A, 1'b0, -5, -5, r, h, bc, dc);
    check("a5_5a_result", 64'(r), 64'h0FF);

    run8(8'hFF, 8'hFF, 1'b1, -5, -5, r, h, bc, dc);
    check("ff_ff_c1_result", 64'(r), 64'h1FF);
    check("hold_during_shift", 64'(h), 64'h0FF);

    run8(8'h10, 8'h20, 1'b0, 2, -5, r, h, bc, dc);
    check("ignored_start_result", 64'(r), 64'h030);
    check("ignored_start_dones", 64'(dc), 64'd1);
    check("ignored_start_idle", 64'(b8), 64'd0);

    run8(8'h7F, 8'h01, 1'b0, -5, 4, r, h, bc, dc);
    check("aborted_dones", 64'(dc), 64'd0);
    check("aborted_outputs", 64'({c8, s8}), 64'd0);

    run8(8'h7F, 8'h01, 1'b0, -5, -5, r, h, bc, dc);
    check("after_reset_result", 64'(r), 64'h080);

    @(negedge clk);
    rnd_mode = 1'b1;
    wait (fin_cnt == 3);
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end
endmodule
